// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcodes, next-PC select encodings and
// the fetch state machine encoding.
package cpu_pkg;

   localparam logic [4:0] OP_HLT = 5'd23;

   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_JMP = 2'd1;
   localparam logic [1:0] PC_JZ  = 2'd2;
   localparam logic [1:0] PC_JN  = 2'd3;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_e;

   function automatic logic [4:0] opcode_of(input logic [15:0] word);
      return word[14:10];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the decode/execute
// side signals exchanged with the fetch unit.
interface fetch_unit_if #(
   parameter int ADDR_W = 10
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ready;
   logic              imem_rvalid;
   logic [15:0]       imem_rdata;
   logic [15:0]       instr;
   logic              instr_valid;
   logic [ADDR_W-1:0] pc;
   logic [1:0]        PC_ctrl;
   logic              acc_zero;
   logic              acc_neg;
   logic              stall;
   logic              halted;

   modport master (
      output imem_req, imem_addr, instr, instr_valid, pc, halted,
      input  imem_ready, imem_rvalid, imem_rdata, PC_ctrl, acc_zero, acc_neg, stall
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid, pc, halted,
      output imem_ready, imem_rvalid, imem_rdata, PC_ctrl, acc_zero, acc_neg, stall
   );
endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC select: increment, unconditional jump, or jump
// on accumulator zero / negative.
module pc_next_logic
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] target,
   input  logic [1:0]        pc_ctrl,
   input  logic              acc_zero,
   input  logic              acc_neg,
   output logic [ADDR_W-1:0] next_pc
);
   logic [ADDR_W-1:0] pc_inc_s;

   assign pc_inc_s = pc + ADDR_W'(1);

   // Select the successor address
   always_comb begin
      next_pc = pc_inc_s;
      case (pc_ctrl)
         PC_INC:  next_pc = pc_inc_s;
         PC_JMP:  next_pc = target;
         PC_JZ:   if (acc_zero) next_pc = target; else next_pc = pc_inc_s;
         PC_JN:   if (acc_neg)  next_pc = target; else next_pc = pc_inc_s;
         default: next_pc = pc_inc_s;
      endcase
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and the
// FETCH/WAIT/EXEC/HALT sequencer driving the instruction-memory handshake.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input logic        clk,
   input logic        rst,
   fetch_unit_if.master bus
);
   fetch_state_e      state_r;
   fetch_state_e      state_next_s;
   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] pc_next_s;
   logic [15:0]       instr_r;
   logic              is_hlt_s;
   logic              req_s;
   logic              valid_s;
   logic              halted_s;

   assign is_hlt_s = (opcode_of(instr_r) == OP_HLT);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_FETCH;
      else     state_r <= state_next_s;
   end

   // Next-state decode
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_FETCH: if (bus.imem_ready)  state_next_s = ST_WAIT;  else state_next_s = ST_FETCH;
         ST_WAIT:  if (bus.imem_rvalid) state_next_s = ST_EXEC;  else state_next_s = ST_WAIT;
         ST_EXEC: begin
            if (bus.stall)     state_next_s = ST_EXEC;
            else if (is_hlt_s) state_next_s = ST_HALT;
            else               state_next_s = ST_FETCH;
         end
         ST_HALT:  state_next_s = ST_HALT;
         default:  state_next_s = ST_FETCH;
      endcase
   end

   // Output decode; reset masks the request so nothing leaves during reset
   always_comb begin
      req_s    = 1'b0;
      valid_s  = 1'b0;
      halted_s = 1'b0;
      case (state_r)
         ST_FETCH: req_s    = ~rst;
         ST_WAIT:  req_s    = 1'b0;
         ST_EXEC:  valid_s  = 1'b1;
         ST_HALT:  halted_s = 1'b1;
         default:  req_s    = 1'b0;
      endcase
   end

   // Program counter: advances only when an instruction retires
   always_ff @(posedge clk) begin
      if (rst)
         pc_r <= '0;
      else if (state_r == ST_EXEC && !bus.stall && !is_hlt_s)
         pc_r <= pc_next_s;
      else
         pc_r <= pc_r;
   end

   // Instruction register: loads only on the response in WAIT
   always_ff @(posedge clk) begin
      if (rst)
         instr_r <= 16'h0000;
      else if (state_r == ST_WAIT && bus.imem_rvalid)
         instr_r <= bus.imem_rdata;
      else
         instr_r <= instr_r;
   end

   pc_next_logic #(.ADDR_W(ADDR_W)) u_pc_next (
      .pc       (pc_r),
      .target   (instr_r[ADDR_W-1:0]),
      .pc_ctrl  (bus.PC_ctrl),
      .acc_zero (bus.acc_zero),
      .acc_neg  (bus.acc_neg),
      .next_pc  (pc_next_s)
   );

   assign bus.imem_req    = req_s;
   assign bus.imem_addr   = pc_r;
   assign bus.pc          = pc_r;
   assign bus.instr       = instr_r;
   assign bus.instr_valid = valid_s;
   assign bus.halted      = halted_s;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for next-PC selection and
// handshake stretching, plus hand-written halt, reset and wrap sequences.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic rst_b;
   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(10)) bus_a ();
   fetch_unit_if #(.ADDR_W(4))  bus_b ();

   fetch_unit #(.ADDR_W(10)) dut_a (.clk(clk), .rst(rst),   .bus(bus_a));
   fetch_unit #(.ADDR_W(4))  dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] word;
      logic [1:0]  ctrl;
      logic        z;
      logic        n;
      int          rdly;
      int          vdly;
      int          stalls;
      logic [9:0]  exp_pc;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one fetch on DUT A from the FETCH state to the first EXEC cycle
   task automatic fetch_a(input logic [15:0] word, input int rdly, input int vdly,
                          input logic [9:0] addr, input logic [15:0] prev);
      for (int i = 0; i < rdly; i++) begin
         bus_a.imem_ready  = 1'b0;
         bus_a.imem_rvalid = 1'b1;
         bus_a.imem_rdata  = 16'hFFFF;
         chk("fetch_req_held", 32'(bus_a.imem_req), 32'd1);
         chk("fetch_addr_stable", 32'(bus_a.imem_addr), 32'(addr));
         @(negedge clk);
      end
      bus_a.imem_rvalid = 1'b0;
      chk("fetch_req", 32'(bus_a.imem_req), 32'd1);
      chk("fetch_addr", 32'(bus_a.imem_addr), 32'(addr));
      bus_a.imem_ready = 1'b1;
      @(negedge clk);
      bus_a.imem_ready = 1'b0;
      for (int i = 0; i < vdly; i++) begin
         chk("wait_req", 32'(bus_a.imem_req), 32'd0);
         chk("wait_instr_hold", 32'(bus_a.instr), 32'(prev));
         @(negedge clk);
      end
      chk("wait_instr_hold_last", 32'(bus_a.instr), 32'(prev));
      bus_a.imem_rvalid = 1'b1;
      bus_a.imem_rdata  = word;
      @(negedge clk);
      bus_a.imem_rvalid = 1'b0;
      bus_a.imem_rdata  = 16'hFFFF;
      chk("exec_instr", 32'(bus_a.instr), 32'(word));
      chk("exec_valid", 32'(bus_a.instr_valid), 32'd1);
   endtask

   // Hold EXEC for some stall cycles with decoy controls, then retire
   task automatic exec_a(input logic [1:0] ctrl, input logic z, input logic n, input int stalls,
                         input logic [9:0] cur_pc, input logic [9:0] exp_pc);
      for (int i = 0; i < stalls; i++) begin
         bus_a.PC_ctrl  = ~ctrl;
         bus_a.acc_zero = ~z;
         bus_a.acc_neg  = ~n;
         bus_a.stall    = 1'b1;
         @(negedge clk);
         chk("stall_valid", 32'(bus_a.instr_valid), 32'd1);
         chk("stall_pc", 32'(bus_a.pc), 32'(cur_pc));
      end
      bus_a.PC_ctrl  = ctrl;
      bus_a.acc_zero = z;
      bus_a.acc_neg  = n;
      bus_a.stall    = 1'b0;
      @(negedge clk);
      chk("next_pc", 32'(bus_a.pc), 32'(exp_pc));
      chk("next_req", 32'(bus_a.imem_req), 32'd1);
      chk("next_valid", 32'(bus_a.instr_valid), 32'd0);
   endtask

   initial begin
      logic [9:0]  cur;
      logic [15:0] prev;

      vecs[0] = '{16'h0155, PC_JMP, 1'b0, 1'b0, 0, 0, 0, 10'h155};
      vecs[1] = '{16'h0000, PC_JZ,  1'b0, 1'b0, 0, 0, 0, 10'h156};
      vecs[2] = '{16'h0020, PC_JN,  1'b0, 1'b1, 0, 0, 0, 10'h020};
      vecs[3] = '{16'h0100, PC_JZ,  1'b1, 1'b0, 3, 2, 0, 10'h100};
      vecs[4] = '{16'h03FF, PC_INC, 1'b0, 1'b0, 0, 1, 4, 10'h101};
      vecs[5] = '{16'h03FF, PC_JMP, 1'b0, 1'b0, 1, 0, 0, 10'h3FF};
      vecs[6] = '{16'h0000, PC_INC, 1'b1, 1'b1, 0, 0, 0, 10'h000};
      vecs[7] = '{16'h8005, PC_JN,  1'b0, 1'b0, 0, 0, 1, 10'h001};

      rst = 1'b1;
      rst_b = 1'b1;
      bus_a.imem_ready = 1'b0; bus_a.imem_rvalid = 1'b0; bus_a.imem_rdata = 16'h0000;
      bus_a.PC_ctrl = PC_INC;  bus_a.acc_zero = 1'b0;    bus_a.acc_neg = 1'b0; bus_a.stall = 1'b0;
      bus_b.imem_ready = 1'b0; bus_b.imem_rvalid = 1'b0; bus_b.imem_rdata = 16'h0000;
      bus_b.PC_ctrl = PC_INC;  bus_b.acc_zero = 1'b0;    bus_b.acc_neg = 1'b0; bus_b.stall = 1'b0;

      // Reset held two cycles with memory ready: no request may escape
      bus_a.imem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_req", 32'(bus_a.imem_req), 32'd0);
         chk("rst_pc", 32'(bus_a.pc), 32'd0);
         chk("rst_instr", 32'(bus_a.instr), 32'd0);
         chk("rst_valid", 32'(bus_a.instr_valid), 32'd0);
         chk("rst_halted", 32'(bus_a.halted), 32'd0);
      end
      bus_a.imem_ready = 1'b0;
      rst = 1'b0;
      #1;
      chk("first_req", 32'(bus_a.imem_req), 32'd1);
      chk("first_addr", 32'(bus_a.imem_addr), 32'd0);

      cur  = 10'h000;
      prev = 16'h0000;
      for (int v = 0; v < 8; v++) begin
         fetch_a(vecs[v].word, vecs[v].rdly, vecs[v].vdly, cur, prev);
         exec_a(vecs[v].ctrl, vecs[v].z, vecs[v].n, vecs[v].stalls, cur, vecs[v].exp_pc);
         prev = vecs[v].word;
         cur  = vecs[v].exp_pc;
      end

      // Halt opcode: stops at the current pc and never requests again
      fetch_a(16'h5C00, 0, 0, cur, prev);
      bus_a.PC_ctrl = PC_JMP;
      bus_a.stall   = 1'b0;
      @(negedge clk);
      chk("halt_halted", 32'(bus_a.halted), 32'd1);
      chk("halt_valid", 32'(bus_a.instr_valid), 32'd0);
      chk("halt_pc", 32'(bus_a.pc), 32'(cur));
      bus_a.imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("halt_no_req", 32'(bus_a.imem_req), 32'd0);
         chk("halt_sticky", 32'(bus_a.halted), 32'd1);
      end
      bus_a.imem_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("halt_rst_pc", 32'(bus_a.pc), 32'd0);
      chk("halt_rst_halted", 32'(bus_a.halted), 32'd0);
      rst = 1'b0;
      #1;
      chk("halt_rst_req", 32'(bus_a.imem_req), 32'd1);

      // Reset while WAIT, stale response arrives afterwards in FETCH
      fetch_a(16'h02AA, 0, 0, 10'h000, 16'h0000);
      exec_a(PC_JMP, 1'b0, 1'b0, 0, 10'h000, 10'h2AA);
      bus_a.imem_ready = 1'b1;
      @(negedge clk);
      bus_a.imem_ready = 1'b0;
      chk("midwait_req", 32'(bus_a.imem_req), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("midwait_rst_instr", 32'(bus_a.instr), 32'd0);
      chk("midwait_rst_pc", 32'(bus_a.pc), 32'd0);
      rst = 1'b0;
      bus_a.imem_rvalid = 1'b1;
      bus_a.imem_rdata  = 16'h1234;
      @(negedge clk);
      bus_a.imem_rvalid = 1'b0;
      chk("stale_instr", 32'(bus_a.instr), 32'd0);
      chk("stale_req", 32'(bus_a.imem_req), 32'd1);
      chk("stale_valid", 32'(bus_a.instr_valid), 32'd0);
      chk("stale_addr", 32'(bus_a.imem_addr), 32'd0);

      // Narrow PC: 17 sequential instructions wrap 15 -> 0
      rst_b = 1'b0;
      #1;
      for (int k = 0; k < 17; k++) begin
         chk("wrap_req", 32'(bus_b.imem_req), 32'd1);
         chk("wrap_addr", 32'(bus_b.imem_addr), 32'(k % 16));
         bus_b.imem_ready = 1'b1;
         @(negedge clk);
         bus_b.imem_ready  = 1'b0;
         bus_b.imem_rvalid = 1'b1;
         bus_b.imem_rdata  = 16'h0000;
         @(negedge clk);
         bus_b.imem_rvalid = 1'b0;
         chk("wrap_valid", 32'(bus_b.instr_valid), 32'd1);
         @(negedge clk);
      end
      chk("wrap_final_pc", 32'(bus_b.pc), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
